// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Brief    : N-channel run-time programmable clock/strobe divider with
//            shadowed, glitch-free reconfiguration and sync realignment.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                                         clk_in,
    input  logic                                         rst,
    input  logic                                         ce,
    input  logic                                         cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]                             cfg_div,
    input  logic [CNT_W-1:0]                             cfg_high,
    input  logic [CNT_W-1:0]                             cfg_phase,
    input  logic                                         sync,
    output logic [N_CH-1:0]                              cfg_pend,
    output logic [N_CH-1:0]                              tick,
    output logic [N_CH-1:0]                              clk_out
);

    localparam int               CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] c_def_div  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_def_high = CNT_W'(DEFAULT_DIV / 2);
    localparam logic [CNT_W-1:0] c_zero     = '0;
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_two      = CNT_W'(2);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_div, r_high, r_phase;
        logic [CNT_W-1:0] r_sh_div, r_sh_high, r_sh_phase;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pend, r_clk, r_tick;

        logic             w_sel, w_en, w_wrap, w_commit;
        logic [CNT_W-1:0] w_div, w_high, w_phase, w_ld, w_inc;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_clk_nxt, w_tick_nxt, w_pend_nxt;

        assign w_sel = cfg_we && (cfg_ch == CH_W'(gi));

        always_comb begin
            w_en       = (r_div >= c_two);
            w_wrap     = ce && w_en && (r_cnt == r_div - c_one);
            // A disabled channel has no boundary to wait for, so a pending shadow lands at once.
            w_commit   = r_pend && (sync || w_wrap || !w_en);
            w_div      = w_commit ? r_sh_div   : r_div;
            w_high     = w_commit ? r_sh_high  : r_high;
            w_phase    = w_commit ? r_sh_phase : r_phase;
            w_ld       = (w_phase < w_div) ? w_phase : c_zero;
            w_inc      = r_cnt + c_one;
            w_cnt_nxt  = r_cnt;
            w_clk_nxt  = r_clk;
            w_tick_nxt = 1'b0;
            w_pend_nxt = w_sel || (r_pend && !w_commit);
            if (sync) begin
                if (w_div >= c_two) begin
                    w_cnt_nxt = w_ld;
                    w_clk_nxt = (w_ld < w_high);
                end else begin
                    w_cnt_nxt = c_zero;
                    w_clk_nxt = 1'b0;
                end
            end else if (!w_en) begin
                // Park one short of the wrap so the first counted edge starts a full period.
                w_cnt_nxt = (w_commit && (w_div >= c_two)) ? (w_div - c_one) : c_zero;
                w_clk_nxt = 1'b0;
            end else if (w_wrap) begin
                w_cnt_nxt = c_zero;
                if (w_div >= c_two) begin
                    w_clk_nxt  = (c_zero < w_high);
                    w_tick_nxt = 1'b1;
                end else begin
                    w_clk_nxt  = 1'b0;
                end
            end else if (ce) begin
                w_cnt_nxt = w_inc;
                w_clk_nxt = (w_inc < r_high);
            end
        end

        always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
                r_div      <= c_def_div;
                r_high     <= c_def_high;
                r_phase    <= c_zero;
                r_sh_div   <= c_def_div;
                r_sh_high  <= c_def_high;
                r_sh_phase <= c_zero;
                r_pend     <= 1'b0;
                r_cnt      <= c_def_div - c_one;
                r_clk      <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                if (w_commit) begin
                    r_div   <= r_sh_div;
                    r_high  <= r_sh_high;
                    r_phase <= r_sh_phase;
                end
                if (w_sel) begin
                    r_sh_div   <= cfg_div;
                    r_sh_high  <= cfg_high;
                    r_sh_phase <= cfg_phase;
                end
                r_pend <= w_pend_nxt;
                r_cnt  <= w_cnt_nxt;
                r_clk  <= w_clk_nxt;
                r_tick <= w_tick_nxt;
            end
        end

        assign cfg_pend[gi] = r_pend;
        assign tick[gi]     = r_tick;
        assign clk_out[gi]  = r_clk;
    end

endmodule
`default_nettype wire
